alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (legal 8..64, power of two).
REQ-002 Parameter SHW, default $clog2(WIDTH), derived shift-amount width; not overridden.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  operation request valid.
REQ-006 in_ready  out  1  unit accepts request this cycle.
REQ-007 op  in  5  operation code, encodings in shared package.
REQ-008 rs  in  WIDTH  first operand.
REQ-009 rm  in  WIDTH  second operand (register or pre-extended immediate).
REQ-010 out_valid  out  1  result valid, held until consumed.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 res  out  WIDTH  result value.
REQ-013 t_written  out  1  high when the result updates the T flag.
REQ-014 t  out  1  T-flag value, meaningful only when t_written=1.
REQ-015 busy  out  1  iterative multiply/divide in progress.

Function
REQ-016 Accept on in_valid&&in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-017 Single-cycle ops (ADD, SUB, AND, OR, XOR, NOT, NEG, SLL, SRL, SRA, SLT, SLTU, CMP, PASS): out_valid asserted the cycle after acceptance.
REQ-018 Arithmetic modulo 2^WIDTH, no overflow flag; NOT=~rs, NEG=-rs, PASS=rs.
REQ-019 Shifts use rm[SHW-1:0] as amount; SRA sign-fills from rs[WIDTH-1]; amount 0 returns rs.
REQ-020 SLT signed, SLTU unsigned: t=(rs<rm), t_written=1, res=0.
REQ-021 CMP: t=(rs!=rm), t_written=1, res=0; all other ops t_written=0, t=0.
REQ-022 MUL (low WIDTH bits of unsigned product), MULHU (high WIDTH bits), DIVU (quotient), REMU (remainder): iterative, one bit per cycle, out_valid exactly WIDTH+1 cycles after acceptance.
REQ-023 States IDLE -> MUL or DIV on accepted iterative op; MUL/DIV -> IDLE after WIDTH iterations, loading the output register; busy=1 only in MUL/DIV.
REQ-024 Divide by zero: DIVU res = all ones, REMU res = rs; same latency as a normal divide.
REQ-025 Output register (res, t, t_written) frozen while out_valid && !out_ready; out_valid drops the cycle after handshake unless a new result loads the same cycle.
REQ-026 Back-to-back single-cycle ops with out_ready held high: one result per cycle, no bubble.
REQ-027 Iterative op complete while previous result unconsumed: FSM holds in final state until output register free; no result lost or overwritten.
REQ-028 Undefined op codes: treated as PASS with t_written=0.
REQ-029 Operands captured at acceptance; later changes on rs/rm/op have no effect on an in-flight op.

Reset
REQ-030 rst=1 at posedge clk: state=IDLE, out_valid=0, res=0, t=0, t_written=0, busy=0, iteration counter=0.
REQ-031 rst mid-operation aborts any multiply/divide; no result is emitted for it.
REQ-032 in_ready=0 during the rst cycle; in_ready=1 the first cycle after rst deasserts.

Structure
REQ-033 Op encodings, state encoding and iterative-op decode function live in shared package alu_pkg.
REQ-034 Iterative multiply/divide datapath is sub-module alu_muldiv_iter (shift-add multiplier, restoring divider, shared counter); alu_muldiv holds decode, single-cycle ops, FSM and output register.

Verification (WIDTH=16)
REQ-035 ADD rs=16'hFFFF rm=16'h0002 -> res=16'h0001, t_written=0, out_valid one cycle later.
REQ-036 SRA rs=16'h8000 rm=16'h0004 -> res=16'hF800; SLT rs=16'hFFFF rm=16'h0001 -> t=1, t_written=1; SLTU same operands -> t=0.
REQ-037 MULHU rs=16'h1234 rm=16'h5678 -> res=16'h0626 at exactly cycle 17 after acceptance, busy=1 cycles 1-16.
REQ-038 DIVU rs=16'd100 rm=16'd0 -> res=16'hFFFF; REMU same -> res=16'd100; DIVU 100/7 -> 14, REMU -> 2.
REQ-039 out_ready=0 for 5 cycles after ADD result, new op offered -> in_ready=0, res stable, no loss; release -> results in order.
REQ-040 rst asserted at cycle 8 of a DIVU -> out_valid stays 0, busy=0 next cycle, in_ready=1 after rst deasserts.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU with iterative multiply/divide.
package alu_pkg;

  localparam int unsigned OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_NOT   = 5'd5,
    OP_NEG   = 5'd6,
    OP_SLL   = 5'd7,
    OP_SRL   = 5'd8,
    OP_SRA   = 5'd9,
    OP_SLT   = 5'd10,
    OP_SLTU  = 5'd11,
    OP_CMP   = 5'd12,
    OP_PASS  = 5'd13,
    OP_MUL   = 5'd16,
    OP_MULHU = 5'd17,
    OP_DIVU  = 5'd18,
    OP_REMU  = 5'd19
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  function automatic logic is_iter_op(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

  // MULHU and REMU take the upper half of the shared accumulator.
  function automatic logic iter_res_hi(input logic [OP_W-1:0] op);
    return (op == OP_MULHU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing one
// 2*WIDTH accumulator and one iteration counter.
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             mul_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last_c,
  output logic [WIDTH-1:0] lo_c,
  output logic [WIDTH-1:0] hi_c
);

  localparam int unsigned W2 = 2 * WIDTH;

  logic [W2-1:0]    acc_q, acc_d, acc_step;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = acc_q[W2-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opb_q};
    if (mul_mode) begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    if (start) begin
      acc_d = {{WIDTH{1'b0}}, a};
      opb_d = b;
      cnt_d = '0;
    end else if (step) begin
      acc_d = acc_step;
      cnt_d = cnt_q + SHW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
    end
  end

  // Results reflect the step in progress so the final iteration lands directly in the output register.
  assign last_c = (cnt_q == SHW'(WIDTH - 1));
  assign lo_c   = acc_step[WIDTH-1:0];
  assign hi_c   = acc_step[W2-1:WIDTH];

endmodule

// File: rtl/alu_muldiv.sv
// ALU with single-cycle ops, iterative MUL/MULHU/DIVU/REMU and a
// valid/ready registered result.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             t_written,
  output logic             t,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             t_q, t_d;
  logic             tw_q, tw_d;
  logic [4:0]       op_q, op_d;

  logic             out_free;
  logic             iter_start, iter_step, iter_last_c;
  logic [WIDTH-1:0] iter_lo_c, iter_hi_c;
  logic [WIDTH-1:0] alu_res;
  logic             alu_t, alu_tw;
  logic [SHW-1:0]   sh_amt;

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = !rst && (state_q == ST_IDLE) && out_free;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign t         = t_q;
  assign t_written = tw_q;

  // Single-cycle datapath; unknown codes fall through to PASS.
  always_comb begin
    sh_amt  = rm[SHW-1:0];
    alu_res = rs;
    alu_t   = 1'b0;
    alu_tw  = 1'b0;
    case (op)
      OP_ADD:  alu_res = rs + rm;
      OP_SUB:  alu_res = rs - rm;
      OP_AND:  alu_res = rs & rm;
      OP_OR:   alu_res = rs | rm;
      OP_XOR:  alu_res = rs ^ rm;
      OP_NOT:  alu_res = ~rs;
      OP_NEG:  alu_res = -rs;
      OP_SLL:  alu_res = rs << sh_amt;
      OP_SRL:  alu_res = rs >> sh_amt;
      OP_SRA:  alu_res = WIDTH'($signed(rs) >>> sh_amt);
      OP_SLT: begin
        alu_res = '0;
        alu_t   = $signed(rs) < $signed(rm);
        alu_tw  = 1'b1;
      end
      OP_SLTU: begin
        alu_res = '0;
        alu_t   = rs < rm;
        alu_tw  = 1'b1;
      end
      OP_CMP: begin
        alu_res = '0;
        alu_t   = rs != rm;
        alu_tw  = 1'b1;
      end
      default: alu_res = rs;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (iter_start),
    .step     (iter_step),
    .mul_mode (state_q == ST_MUL),
    .a        (rs),
    .b        (rm),
    .last_c   (iter_last_c),
    .lo_c     (iter_lo_c),
    .hi_c     (iter_hi_c)
  );

  // Next state and output-register load; a finished iteration waits until the output slot is free.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    res_d       = res_q;
    t_d         = t_q;
    tw_d        = tw_q;
    op_d        = op_q;
    iter_start  = 1'b0;
    iter_step   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          op_d = op;
          if (is_iter_op(op)) begin
            iter_start = 1'b1;
            state_d    = is_mul_op(op) ? ST_MUL : ST_DIV;
          end else begin
            out_valid_d = 1'b1;
            res_d       = alu_res;
            t_d         = alu_t;
            tw_d        = alu_tw;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (!iter_last_c) begin
          iter_step = 1'b1;
        end else if (out_free) begin
          iter_step   = 1'b1;
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          res_d       = iter_res_hi(op_q) ? iter_hi_c : iter_lo_c;
          t_d         = 1'b0;
          tw_d        = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      t_q         <= 1'b0;
      tw_q        <= 1'b0;
      op_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      t_q         <= t_d;
      tw_q        <= tw_d;
      op_q        <= op_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized self-checking bench for alu_muldiv (WIDTH=16) against an
// arithmetic reference model.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned W2 = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   op;
  logic [W-1:0] rs, rm;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         t_written;
  logic         t;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs        (rs),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .t_written (t_written),
    .t         (t),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_is_iter(input logic [4:0] o);
    return (o == OP_MUL) || (o == OP_MULHU) || (o == OP_DIVU) || (o == OP_REMU);
  endfunction

  function automatic void ref_model(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic tf, output logic tw);
    logic [W2-1:0] p;
    logic [3:0]    amt;
    logic [W-1:0]  ones;
    p    = W2'(a) * W2'(b);
    amt  = b[3:0];
    ones = {W{1'b1}};
    tf   = 1'b0;
    tw   = 1'b0;
    case (o)
      OP_ADD:   r = W'(a + b);
      OP_SUB:   r = W'(a - b);
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOT:   r = ~a;
      OP_NEG:   r = W'(0 - a);
      OP_SLL:   r = W'(a << amt);
      OP_SRL:   r = a >> amt;
      OP_SRA:   r = (a >> amt) | (a[W-1] ? ~(ones >> amt) : '0);
      OP_SLT:   begin r = '0; tw = 1'b1; tf = (int'($signed(a)) < int'($signed(b))); end
      OP_SLTU:  begin r = '0; tw = 1'b1; tf = (a < b); end
      OP_CMP:   begin r = '0; tw = 1'b1; tf = (a != b); end
      OP_MUL:   r = p[W-1:0];
      OP_MULHU: r = p[W2-1:W];
      OP_DIVU:  r = (b == 0) ? ones : W'(a / b);
      OP_REMU:  r = (b == 0) ? a : W'(a % b);
      default:  r = a;
    endcase
  endfunction

  // Issue one op, measure latency/busy, optionally hold the result, then consume it.
  task automatic run_op(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input string tag);
    logic [W-1:0] er;
    logic         et, etw;
    int           lat, bcnt;
    ref_model(o, a, b, er, et, etw);
    in_valid = 1'b1; op = o; rs = a; rm = b;
    #1;
    chk($sformatf("%s.in_ready", tag), in_ready, 1);
    cyc();
    in_valid = 1'b0; op = 5'($urandom); rs = W'($urandom); rm = W'($urandom);
    out_ready = 1'b0;
    lat = 1; bcnt = 0;
    while (!out_valid && lat < 40) begin
      bcnt += int'(busy);
      cyc();
      lat++;
    end
    bcnt += int'(busy);
    chk($sformatf("%s.lat", tag), lat, ref_is_iter(o) ? W + 1 : 1);
    chk($sformatf("%s.busy_cycles", tag), bcnt, ref_is_iter(o) ? W : 0);
    chk($sformatf("%s.res", tag), res, er);
    chk($sformatf("%s.t", tag), t, et);
    chk($sformatf("%s.tw", tag), t_written, etw);
    for (int i = 0; i < stall; i++) begin
      cyc();
      chk($sformatf("%s.hold", tag), {out_valid, res}, {1'b1, er});
    end
    out_ready = 1'b1;
    cyc();
    chk($sformatf("%s.drop", tag), out_valid, 0);
  endtask

  logic [4:0] op_list [21] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NEG, OP_SLL,
                              OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_CMP, OP_PASS, OP_MUL,
                              OP_MULHU, OP_DIVU, OP_REMU, 5'd14, 5'd25, 5'd31};

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] er, er2;
    logic         et, etw;
    logic [4:0]   o;
    logic [W-1:0] a, b;
    int           seen;

    rst = 1'b1; in_valid = 1'b0; op = '0; rs = '0; rm = '0; out_ready = 1'b1;
    cyc();
    cyc();
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.res", res, 0);
    chk("rst.t", {t_written, t}, 0);
    chk("rst.busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", in_ready, 1);

    // Directed corner operations.
    run_op(OP_ADD,   16'hFFFF, 16'h0002, 0, "add_wrap");
    run_op(OP_SRA,   16'h8000, 16'h0004, 1, "sra");
    run_op(OP_SLT,   16'hFFFF, 16'h0001, 0, "slt");
    run_op(OP_SLTU,  16'hFFFF, 16'h0001, 0, "sltu");
    run_op(OP_CMP,   16'h1234, 16'h1234, 0, "cmp_eq");
    run_op(OP_SLL,   16'h00F1, 16'h0000, 0, "sll_zero");
    run_op(OP_MULHU, 16'h1234, 16'h5678, 0, "mulhu");
    run_op(OP_DIVU,  16'd100,  16'd0,    0, "divu_by0");
    run_op(OP_REMU,  16'd100,  16'd0,    0, "remu_by0");
    run_op(OP_DIVU,  16'd100,  16'd7,    0, "divu");
    run_op(OP_REMU,  16'd100,  16'd7,    0, "remu");
    run_op(OP_MUL,   16'hFFFF, 16'hFFFF, 4, "mul_hold");
    run_op(5'd27,    16'hBEEF, 16'h0001, 0, "undef");

    // Backpressure: result held and new op stalled until consumer frees the slot.
    ref_model(OP_ADD, 16'h1111, 16'h2222, er, et, etw);
    ref_model(OP_SUB, 16'h0005, 16'h0003, er2, et, etw);
    out_ready = 1'b0;
    in_valid = 1'b1; op = OP_ADD; rs = 16'h1111; rm = 16'h2222;
    cyc();
    op = OP_SUB; rs = 16'h0005; rm = 16'h0003;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp.stall", {in_ready, out_valid, res}, {1'b0, 1'b1, er});
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    chk("bp.second", {out_valid, res}, {1'b1, er2});
    cyc();
    chk("bp.drain", out_valid, 0);

    // Back-to-back single-cycle ops, one result per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      o = op_list[$urandom_range(0, 13)];
      a = W'($urandom); b = W'($urandom);
      ref_model(o, a, b, er, et, etw);
      in_valid = 1'b1; op = o; rs = a; rm = b;
      cyc();
      chk("b2b.res", {out_valid, t_written, t, res}, {1'b1, etw, et, er});
    end
    in_valid = 1'b0;
    cyc();
    chk("b2b.drain", out_valid, 0);

    // Reset in the middle of a divide.
    in_valid = 1'b1; op = OP_DIVU; rs = 16'd1000; rm = 16'd7;
    cyc();
    in_valid = 1'b0;
    repeat (7) cyc();
    chk("abort.busy_before", busy, 1);
    rst = 1'b1;
    cyc();
    chk("abort.state", {busy, out_valid, in_ready}, 3'b000);
    rst = 1'b0;
    #1;
    chk("abort.in_ready", in_ready, 1);
    seen = 0;
    repeat (20) begin
      cyc();
      seen += int'(out_valid);
    end
    chk("abort.no_result", seen, 0);

    // Random ops including undefined codes and small/zero divisors.
    for (int i = 0; i < 60; i++) begin
      o = op_list[$urandom_range(0, 20)];
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
      run_op(o, a, b, $urandom_range(0, 2), $sformatf("rnd%0d_op%0d", i, o));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
